// File: rtl/csel_sub_pipe_64bit.sv
// Pipelined carry-select subtractor: diff = a - b - bin, one SLICE-bit slice per stage.
// Every stage computes its slice for both borrow-in values and selects on the registered borrow.
module csel_sub_pipe_64bit #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);
    // WIDTH must be an integer multiple of SLICE.
    localparam int NST = WIDTH / SLICE;

    // Handshake: one global enable; stage 0 accepts whenever the whole pipe may advance.
    // in_valid/in_ready and out_valid/out_ready transfer on the same edge when both are high.
    logic en;

    logic             st_valid [NST];
    logic             st_bor   [NST];
    logic [WIDTH-1:0] st_a     [NST];
    logic [WIDTH-1:0] st_b     [NST];
    logic [WIDTH-1:0] st_diff  [NST];

    logic [WIDTH-1:0] nx_diff  [NST];
    logic             nx_bor   [NST];

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Slice subtraction as a + ~b + ~borrow; borrow out is the inverted carry out.
    always_comb begin
        for (int k = 0; k < NST; k++) begin
            logic [SLICE-1:0] as;
            logic [SLICE-1:0] bs;
            logic [SLICE:0]   s0;
            logic [SLICE:0]   s1;
            logic             bo0;
            logic             bo1;
            as  = st_a[k][k*SLICE +: SLICE];
            bs  = st_b[k][k*SLICE +: SLICE];
            s0  = {1'b0, as} + {1'b0, ~bs} + {{SLICE{1'b0}}, 1'b1};
            s1  = {1'b0, as} + {1'b0, ~bs};
            bo0 = ~s0[SLICE];
            bo1 = ~s1[SLICE];
            nx_diff[k] = st_diff[k];
            nx_diff[k][k*SLICE +: SLICE] = st_bor[k] ? s1[SLICE-1:0] : s0[SLICE-1:0];
            nx_bor[k]  = st_bor[k] ? bo1 : bo0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NST; k++) begin
                st_valid[k] <= 1'b0;
                st_bor[k]   <= 1'b0;
                st_a[k]     <= '0;
                st_b[k]     <= '0;
                st_diff[k]  <= '0;
            end
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            st_valid[0] <= in_valid;
            st_bor[0]   <= bin;
            st_a[0]     <= a;
            st_b[0]     <= b;
            st_diff[0]  <= '0;
            for (int k = 1; k < NST; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_bor[k]   <= nx_bor[k-1];
                st_a[k]     <= st_a[k-1];
                st_b[k]     <= st_b[k-1];
                st_diff[k]  <= nx_diff[k-1];
            end
            // Flags come from the completed difference and the operand MSBs carried along.
            out_valid <= st_valid[NST-1];
            diff      <= nx_diff[NST-1];
            bout      <= nx_bor[NST-1];
            zero      <= (nx_diff[NST-1] == '0);
            ovf       <= (st_a[NST-1][WIDTH-1] ^ st_b[NST-1][WIDTH-1])
                       & (st_a[NST-1][WIDTH-1] ^ nx_diff[NST-1][WIDTH-1]);
        end
    end

endmodule
